// File: rtl/alu_181_pkg.sv
// Shared definitions for the nibble-serial 74x181-style ALU: function selects
// and controller state encoding.
package alu_181_pkg;

  localparam logic [3:0] S_ADD = 4'b1001;  // arithmetic, m_bar = 0
  localparam logic [3:0] S_SUB = 4'b0110;  // arithmetic, m_bar = 0
  localparam logic [3:0] S_XOR = 4'b0110;  // logic, m_bar = 1
  localparam logic [3:0] S_AND = 4'b1011;
  localparam logic [3:0] S_OR  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_181_slice.sv
// One combinational 4-bit 74x181 slice with an active-low ripple carry
// (k is low when a carry is present).
module alu_181_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m_bar,
  input  logic       k_0,
  output logic [3:0] f,
  output logic       k_4
);

  logic [3:0] x;
  logic [3:0] y;
  logic       k;

  always_comb begin
    x = '0;
    y = '0;
    f = '0;
    k = k_0;
    for (int i = 0; i < 4; i++) begin
      x[i] = ~(a[i] | (b[i] & s[0]) | (~b[i] & s[1]));
      y[i] = ~((a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]));
      // In logic mode the carry term is forced off so f ignores the chain.
      f[i] = (x[i] ^ y[i]) ^ ~(~m_bar & k);
      k    = x[i] | (y[i] & k);
    end
    k_4 = k;
  end

endmodule

// File: rtl/alu_181_serial.sv
// WIDTH-bit 74x181-style ALU evaluated one nibble per clock, LSB first, with
// the inter-slice carry held in a register and a start/busy/done handshake.
module alu_181_serial
  import alu_181_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SLICES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m_bar,
  input  logic             ci_bar,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             co_bar,
  output logic             a_eq_b
);

  localparam int               IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(SLICES - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] f_q;
  logic [3:0]       s_q;
  logic             m_bar_q;
  logic             carry_q;
  logic             co_bar_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W+1:0] base;
  logic [3:0]       slice_f;
  logic             slice_k4;

  assign base = {idx_q, 2'b00};

  alu_181_slice u_slice (
    .a     (a_q[base +: 4]),
    .b     (b_q[base +: 4]),
    .s     (s_q),
    .m_bar (m_bar_q),
    .k_0   (carry_q),
    .f     (slice_f),
    .k_4   (slice_k4)
  );

  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_bar_q  <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      f_q      <= '0;
      co_bar_q <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          f_q[base +: 4] <= slice_f;
          carry_q        <= slice_k4;
          if (idx_q == LAST) begin
            co_bar_q <= slice_k4;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        // IDLE and DONE accept a new request identically, so back-to-back
        // operations lose no cycle.
        default: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_bar_q <= m_bar;
            carry_q <= ci_bar;
            idx_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign f      = f_q;
  assign co_bar = co_bar_q;
  assign a_eq_b = &f_q;

endmodule

// File: tb/tb_alu_181_serial.sv
// Directed-vector bench for alu_181_serial: table-driven 16-bit operations plus
// handshake/reset sequences and one 32-bit instance.
module tb_alu_181_serial;
  import alu_181_pkg::*;

  logic        clk = 1'b0;
  logic        rst_bar = 1'b0;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  s16 = '0;
  logic        m16 = 1'b0, ci16 = 1'b1;
  logic        busy16, done16, co16, aeq16;
  logic [15:0] f16;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  s32 = '0;
  logic        m32 = 1'b0, ci32 = 1'b1;
  logic        busy32, done32, co32, aeq32;
  logic [31:0] f32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_181_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_bar(rst_bar), .start(start16), .a(a16), .b(b16), .s(s16),
    .m_bar(m16), .ci_bar(ci16), .busy(busy16), .done(done16), .f(f16),
    .co_bar(co16), .a_eq_b(aeq16)
  );

  alu_181_serial #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_bar(rst_bar), .start(start32), .a(a32), .b(b32), .s(s32),
    .m_bar(m32), .ci_bar(ci32), .busy(busy32), .done(done32), .f(f32),
    .co_bar(co32), .a_eq_b(aeq32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m_bar;
    logic        ci_bar;
    logic [15:0] f;
    logic        chk_co;
    logic        co_bar;
    logic        aeq;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch16(input vec_t v);
    a16 = v.a; b16 = v.b; s16 = v.s; m16 = v.m_bar; ci16 = v.ci_bar;
    start16 = 1'b1;
  endtask

  // Called on the negedge where start16 is high; returns on the negedge where
  // done16 is first seen. poke_at > 0 re-asserts start for one cycle mid-run.
  task automatic wait_done16(input int poke_at, output int lat, output int nbusy);
    bit got = 0;
    lat = 0;
    nbusy = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done16) got = 1;
      else if (busy16) nbusy++;
      if (!got) begin
        if (lat == 1) begin
          start16 = 1'b0;
          a16 = 16'($urandom); b16 = 16'($urandom);
          s16 = 4'($urandom); m16 = 1'($urandom); ci16 = 1'($urandom);
        end
        if (poke_at > 0 && lat == poke_at) begin
          start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; s16 = S_ADD; m16 = 1'b0;
        end
        if (poke_at > 0 && lat == poke_at + 1) start16 = 1'b0;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done16 timeout: got no done, expected done within 40 cycles");
    end
  endtask

  task automatic check_result16(input string tag, input vec_t v);
    chk({tag, " f"}, 32'(f16), 32'(v.f));
    if (v.chk_co) chk({tag, " co_bar"}, 32'(co16), 32'(v.co_bar));
    chk({tag, " a_eq_b"}, 32'(aeq16), 32'(v.aeq));
  endtask

  initial begin
    int lat, nbusy, ndone;
    vec_t v2;

    tbl[0] = '{16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'hF0F0, 16'h0F0C, S_OR,  1'b1, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'hF0F0, 16'h3C3C, S_AND, 1'b1, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h00FF, 16'h0000, S_ADD, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{16'hFFFF, 16'h0002, S_ADD, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy16", 32'(busy16), 32'd0);
    chk("rst done16", 32'(done16), 32'd0);
    chk("rst f16", 32'(f16), 32'd0);
    chk("rst co16", 32'(co16), 32'd1);
    chk("rst aeq16", 32'(aeq16), 32'd0);
    chk("rst f32", f32, 32'd0);
    chk("rst co32", 32'(co32), 32'd1);
    rst_bar = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch16(tbl[i]);
      wait_done16(0, lat, nbusy);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd5);
      chk($sformatf("v%0d busy cycles", i), 32'(nbusy), 32'd4);
      check_result16($sformatf("v%0d", i), tbl[i]);
    end

    // start while busy is ignored
    @(negedge clk);
    launch16(tbl[0]);
    wait_done16(2, lat, nbusy);
    chk("ignore latency", 32'(lat), 32'd5);
    check_result16("ignore", tbl[0]);
    @(negedge clk);
    chk("ignore no rerun busy", 32'(busy16), 32'd0);
    chk("ignore no rerun done", 32'(done16), 32'd0);
    chk("ignore f held", 32'(f16), 32'h2233);

    // start held in the DONE cycle is accepted back-to-back
    @(negedge clk);
    launch16(tbl[1]);
    wait_done16(0, lat, nbusy);
    check_result16("b2b first", tbl[1]);
    v2 = tbl[4];
    launch16(v2);
    wait_done16(0, lat, nbusy);
    chk("b2b second latency", 32'(lat), 32'd5);
    check_result16("b2b second", v2);

    // reset during RUN aborts with no done pulse
    @(negedge clk);
    launch16(tbl[9]);
    wait_done16(0, lat, nbusy);
    check_result16("pre-reset", tbl[9]);
    @(negedge clk);
    launch16(tbl[0]);
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst_bar = 1'b0;
    @(negedge clk);
    chk("rst run busy", 32'(busy16), 32'd0);
    chk("rst run done", 32'(done16), 32'd0);
    chk("rst run f", 32'(f16), 32'd0);
    chk("rst run co_bar", 32'(co16), 32'd1);
    rst_bar = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done16 || busy16) ndone++;
    end
    chk("rst run no done", 32'(ndone), 32'd0);

    // 32-bit instance: carry ripples through all eight slices
    @(negedge clk);
    a32 = 32'h89ABCDEF; b32 = 32'h76543211; s32 = S_ADD; m32 = 1'b0; ci32 = 1'b1;
    start32 = 1'b1;
    lat = 0;
    nbusy = 0;
    ndone = 0;
    while (ndone == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done32) ndone = 1;
      else if (busy32) nbusy++;
      if (lat == 1) begin
        start32 = 1'b0;
        a32 = 32'($urandom); b32 = 32'($urandom);
      end
    end
    chk("w32 latency", 32'(lat), 32'd9);
    chk("w32 busy cycles", 32'(nbusy), 32'd8);
    chk("w32 f", f32, 32'h00000000);
    chk("w32 co_bar", 32'(co32), 32'd0);
    chk("w32 a_eq_b", 32'(aeq32), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
